// File: rtl/seq_multdiv.sv
// seq_multdiv: multi-cycle signed 32-bit multiplier (shift-add) and divider (restoring),
// one bit per cycle, fixed 33-cycle start-to-ready latency.
module seq_multdiv (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t state;
  logic [5:0] count;
  logic [31:0] am, bm, abs_a, abs_b, quo;
  logic [63:0] acc, sh, prod;
  logic [32:0] diff;
  logic neg, div_op, dz, ov;
  always_comb begin
    abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    abs_b = data_operandB[31] ? -data_operandB : data_operandB;
    sh = {acc[62:0], 1'b0};
    diff = {1'b0, sh[63:32]} - {1'b0, bm};
    prod = neg ? -acc : acc;
    quo = neg ? -acc[31:0] : acc[31:0];
  end
  // Multiply consumes |B| MSB-first from bm; divide keeps remainder:quotient in acc.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      count <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      state <= ctrl_MULT ? MULT : DIV;
      div_op <= !ctrl_MULT;
      count <= '0;
      am <= abs_a;
      bm <= abs_b;
      acc <= ctrl_MULT ? 64'd0 : {32'd0, abs_a};
      neg <= data_operandA[31] ^ data_operandB[31];
      dz <= data_operandB == 32'd0;
      ov <= data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
      busy <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        MULT: begin
          acc <= sh + (bm[31] ? {32'd0, am} : 64'd0);
          bm <= {bm[30:0], 1'b0};
          count <= count + 6'd1;
          state <= count == 6'd31 ? DONE : MULT;
        end
        DIV: begin
          acc <= diff[32] ? sh : {diff[31:0], sh[31:1], 1'b1};
          count <= count + 6'd1;
          state <= count == 6'd31 ? DONE : DIV;
        end
        DONE: begin
          data_result <= div_op ? (dz ? 32'd0 : quo) : prod[31:0];
          data_exception <= div_op ? (dz || ov) : prod[63:32] != {32{prod[31]}};
          data_resultRDY <= 1'b1;
          count <= '0;
          state <= IDLE;
        end
        default: busy <= 1'b0;
      endcase
    end
  end
endmodule
